// File: rtl/nes_pad_reader_pkg.sv
// Shared constants for the NES pad reader: button bit positions, FSM state
// encoding and default timing for a 25.175 MHz system clock.
package nes_pkg;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   // 60 Hz poll rate and 6 us protocol half-period at 25.175 MHz
   localparam int DEFAULT_POLL_DIV = 419583;
   localparam int DEFAULT_HALF_BIT = 152;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LATCH    = 3'd1,
      ST_PULSE_HI = 3'd2,
      ST_PULSE_LO = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   // Bits needed to hold the value n itself, never less than one
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/nes_pad_reader_tick_counter.sv
// Wrap counter: counts 0..limit-1 while enabled and flags the last count
// with roll; clr forces it back to zero.
module tick_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] limit,
   output logic             roll
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;

   assign roll = en && (count_reg == (limit - ONE));

   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (en) begin
         count_next = roll ? '0 : (count_reg + ONE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller reader: drives latch/pulse pins once per poll period and
// publishes the 8 buttons active-high. Define NES_PAD_READER_SYNC_EN to
// pass nes_data through a 2-flop synchronizer before sampling.
module nes_pad_reader
   import nes_pkg::*;
#(
   parameter int POLL_DIV = DEFAULT_POLL_DIV,
   parameter int HALF_BIT = DEFAULT_HALF_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_pulse,
   output logic [7:0] buttons,
   output logic       buttons_valid,
   output logic [7:0] press_edge,
   output logic       busy
);

   localparam int PW_POLL  = cnt_width(POLL_DIV);
   localparam int PW_PHASE = cnt_width(2 * HALF_BIT);
   localparam logic [PW_POLL-1:0]  POLL_LEN  = PW_POLL'(POLL_DIV);
   localparam logic [PW_PHASE-1:0] LATCH_LEN = PW_PHASE'(2 * HALF_BIT);
   localparam logic [PW_PHASE-1:0] HALF_LEN  = PW_PHASE'(HALF_BIT);

   state_t              state_reg;
   state_t              state_next;
   logic [3:0]          bit_idx_reg;
   logic [3:0]          bit_idx_next;
   logic [7:0]          shift_reg;
   logic [7:0]          shift_next;
   logic [7:0]          sample_en;
   logic [7:0]          buttons_reg;
   logic [7:0]          buttons_next;
   logic [7:0]          press_edge_reg;
   logic [7:0]          press_edge_next;
   logic                valid_reg;
   logic                valid_next;
   logic                latch_reg;
   logic                pulse_reg;
   logic                busy_reg;
   logic                tick;
   logic                phase_last;
   logic                phase_en;
   logic                phase_clr;
   logic [PW_PHASE-1:0] phase_limit;
   logic                d;

`ifdef NES_PAD_READER_SYNC_EN
   logic [1:0] sync_reg;

   // Idle-high reset value matches a released / disconnected pad
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], nes_data};
      end
   end

   assign d = sync_reg[1];
`else
   assign d = nes_data;
`endif

   // Free-running poll counter; never stalls, ticks on its last count
   tick_counter #(.WIDTH(PW_POLL)) u_poll (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .clr   (1'b0),
      .limit (POLL_LEN),
      .roll  (tick)
   );

   assign phase_en    = (state_reg == ST_LATCH) || (state_reg == ST_PULSE_HI) ||
                        (state_reg == ST_PULSE_LO);
   assign phase_clr   = (state_reg == ST_IDLE);
   assign phase_limit = (state_reg == ST_LATCH) ? LATCH_LEN : HALF_LEN;

   // Phase timer wraps on each phase's last cycle, so every phase starts at 0
   tick_counter #(.WIDTH(PW_PHASE)) u_phase (
      .clk   (clk),
      .reset (reset),
      .en    (phase_en),
      .clr   (phase_clr),
      .limit (phase_limit),
      .roll  (phase_last)
   );

   // Bit 0 is captured at the end of LATCH, bit k at the end of pulse k's low half
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_shift
         if (gi == 0) begin : g_first
            assign sample_en[gi] = (state_reg == ST_LATCH) && phase_last;
         end else begin : g_rest
            assign sample_en[gi] = (state_reg == ST_PULSE_LO) && phase_last &&
                                   (bit_idx_reg == 4'(gi - 1));
         end
         assign shift_next[gi] = sample_en[gi] ? d : shift_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      bit_idx_next    = bit_idx_reg;
      buttons_next    = buttons_reg;
      press_edge_next = '0;
      valid_next      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (tick) begin
               state_next   = ST_LATCH;
               bit_idx_next = '0;
            end
         end
         ST_LATCH: begin
            if (phase_last) begin
               state_next = ST_PULSE_HI;
            end
         end
         ST_PULSE_HI: begin
            if (phase_last) begin
               state_next = ST_PULSE_LO;
            end
         end
         ST_PULSE_LO: begin
            if (phase_last) begin
               bit_idx_next = bit_idx_reg + 4'd1;
               state_next   = (bit_idx_next == 4'd8) ? ST_DONE : ST_PULSE_HI;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Registered on entry so the new word appears in the DONE cycle itself
      if ((state_next == ST_DONE) && (state_reg != ST_DONE)) begin
         buttons_next    = ~shift_next;
         press_edge_next = ~shift_next & ~buttons_reg;
         valid_next      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         bit_idx_reg    <= '0;
         shift_reg      <= '0;
         buttons_reg    <= '0;
         press_edge_reg <= '0;
         valid_reg      <= 1'b0;
         latch_reg      <= 1'b0;
         pulse_reg      <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         bit_idx_reg    <= bit_idx_next;
         shift_reg      <= shift_next;
         buttons_reg    <= buttons_next;
         press_edge_reg <= press_edge_next;
         valid_reg      <= valid_next;
         latch_reg      <= (state_next == ST_LATCH);
         pulse_reg      <= (state_next == ST_PULSE_HI);
         busy_reg       <= (state_next != ST_IDLE);
      end
   end

   assign nes_latch     = latch_reg;
   assign nes_pulse     = pulse_reg;
   assign buttons       = buttons_reg;
   assign buttons_valid = valid_reg;
   assign press_edge    = press_edge_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: a behavioural pad reacts to latch/pulse, a
// scoreboard checks each update and the pin framing is checked every cycle.
module tb_nes_pad_reader;

   localparam int P = 100;
   localparam int H = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       nes_data = 1'b1;
   logic       nes_latch;
   logic       nes_pulse;
   logic [7:0] buttons;
   logic       buttons_valid;
   logic [7:0] press_edge;
   logic       busy;

   nes_pad_reader #(.POLL_DIV(P), .HALF_BIT(H)) dut (
      .clk           (clk),
      .reset         (reset),
      .nes_data      (nes_data),
      .nes_latch     (nes_latch),
      .nes_pulse     (nes_pulse),
      .buttons       (buttons),
      .buttons_valid (buttons_valid),
      .press_edge    (press_edge),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ecyc;
      logic [7:0] btn;
      logic [7:0] pe;
   } exp_t;

   exp_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [7:0] ctrl_btn = 8'h00;
   logic [7:0] prev_btn = 8'h00;
   logic [7:0] exp_buttons = 8'h00;
   bit         float_en = 1'b0;
   bit         direct_en = 1'b0;

   // Expected {latch, pulse, busy, valid} from the protocol timeline
   function automatic logic [3:0] frame(input int c);
      logic [3:0] f;
      int r;
      f = 4'b0000;
      if (c >= P) begin
         r = c % P;
         f[3] = (r < 2 * H);
         f[2] = (r >= 2 * H) && (r < 18 * H) && (((r - 2 * H) % (2 * H)) < H);
         f[1] = (r <= 18 * H);
         f[0] = (r == 18 * H);
      end
      return f;
   endfunction

   // Pin pattern around the first two sample points (r=3 and r=7)
   function automatic logic direct_pin(input int r);
      return !((r < 2) || ((r >= 4) && (r < 6)));
   endfunction

   // Monitor: cycle numbering restarts at 0 in the cycle after reset is sampled
   initial begin
      exp_t e;
      logic [3:0] f;
      forever begin
         @(posedge clk);
         if (reset) begin
            cyc = 0;
            exp_buttons = 8'h00;
         end else begin
            cyc++;
         end
         #1;
         f = frame(cyc);
         total++;
         if ({nes_latch, nes_pulse, busy, buttons_valid} !== f) begin
            bad++;
            $display("FAIL frame cyc=%0d got latch/pulse/busy/valid=%b want=%b",
                     cyc, {nes_latch, nes_pulse, busy, buttons_valid}, f);
         end
         if (buttons_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_valid cyc=%0d got buttons=%02h want no update",
                        cyc, buttons);
            end else begin
               e = exp_q.pop_front();
               exp_buttons = e.btn;
               if ((cyc != e.ecyc) || (buttons !== e.btn) || (press_edge !== e.pe)) begin
                  bad++;
                  $display("FAIL update got cyc=%0d buttons=%02h edge=%02h want cyc=%0d buttons=%02h edge=%02h",
                           cyc, buttons, press_edge, e.ecyc, e.btn, e.pe);
               end else begin
                  $display("update cyc=%0d buttons=%02h edge=%02h", cyc, buttons, press_edge);
               end
            end
         end else begin
            total++;
            if (press_edge !== 8'h00) begin
               bad++;
               $display("FAIL edge_idle cyc=%0d got=%02h want=00", cyc, press_edge);
            end
         end
         total++;
         if (buttons !== exp_buttons) begin
            bad++;
            $display("FAIL buttons_hold cyc=%0d got=%02h want=%02h", cyc, buttons, exp_buttons);
         end
      end
   end

   // Behavioural pad: latch reloads, each pulse rising edge advances one button
   initial begin
      int   idx;
      logic pulse_prev;
      idx = 8;
      pulse_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (nes_latch === 1'b1) begin
            idx = 0;
         end else if ((nes_pulse === 1'b1) && !pulse_prev) begin
            idx++;
         end
         pulse_prev = (nes_pulse === 1'b1);
         if (direct_en) begin
            nes_data = direct_pin(cyc % P);
         end else if (float_en) begin
            nes_data = 1'b1;
         end else begin
            nes_data = (idx < 8) ? ~ctrl_btn[idx] : 1'b1;
         end
      end
   end

   task automatic wait_cyc(input int target);
      int guard;
      guard = 0;
      while ((cyc < target) && (guard < 10 * P)) begin
         @(negedge clk);
         guard++;
      end
      if (cyc < target) begin
         total++;
         bad++;
         $display("FAIL wait_timeout got cyc=%0d want cyc=%0d", cyc, target);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      prev_btn = 8'h00;
      float_en = 1'b0;
      direct_en = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   // Load the pad for poll n and queue the update it must produce
   task automatic run_poll(input int n, input logic [7:0] btn, input bit fl);
      logic [7:0] eff;
      wait_cyc(P * n + 50);
      float_en = fl;
      ctrl_btn = btn;
      eff = fl ? 8'h00 : btn;
      exp_q.push_back('{ecyc: P * (n + 1) + 18 * H, btn: eff, pe: eff & ~prev_btn});
      $display("poll %0d: pad=%02h float=%0d expect buttons=%02h edge=%02h",
               n, btn, fl, eff, eff & ~prev_btn);
      prev_btn = eff;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int last;
      do_reset();

      run_poll(0, 8'h81, 1'b0);
      run_poll(1, 8'h81, 1'b0);
      run_poll(2, 8'h10, 1'b0);
      run_poll(3, 8'h20, 1'b0);
      for (int n = 4; n < 10; n++) begin
         run_poll(n, 8'($urandom), 1'b0);
      end
      for (int n = 10; n < 13; n++) begin
         run_poll(n, 8'($urandom), 1'b1);
      end

      // Poll 13 is cut short by reset during pulse 4
      wait_cyc(P * 13 + 50);
      float_en = 1'b0;
      ctrl_btn = 8'($urandom);
      wait_cyc(P * 14 + 2 * H + 6 * H);
      $display("reset mid-read at cyc=%0d", cyc);
      do_reset();

      for (int n = 0; n < 4; n++) begin
         run_poll(n, 8'($urandom), 1'b0);
      end
      last = 3;
`ifdef NES_PAD_READER_SYNC_EN
      wait_cyc(P * 4 + 50);
      direct_en = 1'b1;
      exp_q.push_back('{ecyc: P * 5 + 18 * H, btn: 8'h03, pe: 8'h03 & ~prev_btn});
      $display("poll 4: direct sync pattern expect buttons=03 edge=%02h", 8'h03 & ~prev_btn);
      prev_btn = 8'h03;
      last = 4;
`endif
      wait_cyc(P * (last + 1) + 60);
      direct_en = 1'b0;

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_updates got pending=%0d want pending=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Reads one NES controller over its latch/pulse/data serial protocol and presents all eight buttons as an active-high parallel word, refreshed once per poll period. It generates the controller latch and pulse pins itself and delivers a one-cycle `buttons_valid` strobe with a newly-pressed edge mask. It sits directly upstream of the pong datapath's paddle/ball control, which needs only the press-edge mask and the current button word. One instance is used per controller.

## Interface
- `POLL_DIV`, 419583: clock cycles per poll period (60 Hz at 25.175 MHz).
- `HALF_BIT`, 152: cycles per 6 µs protocol half-period.
- Constraint: `POLL_DIV` > 18*`HALF_BIT` + 2. `HALF_BIT` ≥ 1.
- `clk`  in  1  system clock, the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `nes_data`  in  1  controller serial data; active-low (0 = pressed).
- `nes_latch`  out  1  controller latch pin, registered.
- `nes_pulse`  out  1  controller clock pin, registered.
- `buttons`  out  8  active-high button state. Bit order: [0] A, [1] B, [2] Select, [3] Start, [4] Up, [5] Down, [6] Left, [7] Right.
- `buttons_valid`  out  1  one-cycle strobe when `buttons` updates.
- `press_edge`  out  8  bits that went 0→1 in this update; valid only with `buttons_valid`, 0 otherwise.
- `busy`  out  1  high from LATCH through DONE.

## Operation
- **Poll counter:** free-running, 0..`POLL_DIV`-1, wraps to 0. `tick` is asserted when count = `POLL_DIV`-1.
- **Tick while not in IDLE:** ignored. The counter never stalls.
- **States:** IDLE, LATCH, PULSE_HI, PULSE_LO, DONE.
- **Phase timer:** counts 0..N-1 within each phase.
- **IDLE:** on `tick`, go to LATCH with timer = 0 and `bit_idx` = 0.
- **LATCH:** lasts 2*`HALF_BIT` cycles. On the last cycle, sample `d` into `shift[0]`, then go to PULSE_HI.
- **PULSE_HI:** lasts `HALF_BIT` cycles, then go to PULSE_LO.
- **PULSE_LO:** lasts `HALF_BIT` cycles. On its last cycle:
  - increment `bit_idx`;
  - if the new `bit_idx` ≤ 7, sample `d` into `shift[bit_idx]`;
  - after the 8th pulse (`bit_idx` = 8), go to DONE; otherwise go to PULSE_HI.
- **DONE:** one cycle.
  - `buttons` ← ~`shift`.
  - `press_edge` ← ~`shift` & ~`buttons`(old).
  - `buttons_valid` ← 1.
  - Return to IDLE.
- **Pin outputs:** `nes_latch` = 1 exactly while in LATCH. `nes_pulse` = 1 exactly while in PULSE_HI. Both are registered from next-state, so no glitches.
- **Sampled signal `d`:** see Configuration.
- **Reset (including mid-read):** the cycle after `reset` is sampled high:
  - state = IDLE, poll count = 0, timer = 0, `bit_idx` = 0, `shift` = 0;
  - `buttons` = 0, `press_edge` = 0, `buttons_valid` = 0, `busy` = 0, `nes_latch` = 0, `nes_pulse` = 0.
  - A partially shifted word is discarded.
- **Disconnected controller** (`nes_data` floats high): reads all zeros, which is legal.

## Timing
- `tick` at cycle t; `nes_latch` high for cycles t+1 … t+2H (H = `HALF_BIT`).
- Pulse k (k = 1..8) is high for cycles t+1+2H+2H(k-1) … t+2H+2H(k-1)+H.
- `buttons_valid` fires at cycle t+18H+1 and lasts exactly 1 cycle. `buttons` changes in that same cycle.
- The first tick after reset occurs at cycle `POLL_DIV`-1.
- Updates are strictly periodic at `POLL_DIV` cycles.

## Configuration
- **`NES_PAD_READER_SYNC_EN` defined:** `d` = `nes_data` passed through a 2-flop synchronizer. Sample points see pin values from 2 cycles earlier.
- **Not defined:** `d` = raw `nes_data`, sampled combinationally at the sample cycle. Use this only where `nes_data` is already synchronous. All other timing is identical.

## Structure
- **Shared package `nes_pkg`:**
  - button index constants `BTN_A` … `BTN_RIGHT` (0..7);
  - state encoding for the five states;
  - default `POLL_DIV` and `HALF_BIT` constants for 25.175 MHz.
- **Sub-module `tick_counter`:** a parameterised wrap counter (limit, enable, clear, `roll`). It is instanced for the poll counter and the phase timer.

## Test plan
Bench parameters: `POLL_DIV`=100, `HALF_BIT`=2, SYNC_EN off unless stated.
- **Framing:** reset, then idle. First tick at cycle 99. Expect `nes_latch` high for cycles 100–103, then 8 pulses each 2 high / 2 low. `buttons_valid` at cycle 136, then again at 236.
- **Bit ordering:** the model drives A=pressed and Right=pressed (`nes_data`=0 for bit slots 0 and 7). Expect `buttons`=8'h81 and `press_edge`=8'h81. Next poll with the same pattern gives `press_edge`=0.
- **Release/press edges:** Up held, then Up released and Down pressed. Expect `buttons` 8'h10 → 8'h20, with `press_edge`=8'h20 on the second update.
- **Reset mid-read:** assert `reset` during pulse 4. The next cycle shows `nes_latch`=`nes_pulse`=0 and `buttons`=0. No `buttons_valid` until cycle 136 after reset release.
- **Floating data:** hold `nes_data`=1 throughout. Expect `buttons`=0, `press_edge`=0, and `buttons_valid` still pulses every 100 cycles.
- **SYNC_EN defined:** the model changes `nes_data` exactly 1 cycle before a sample point. The old value is captured. A change 3 cycles before the sample point is captured.
